// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game end-of-game timer and scoreboard.
`timescale 1ns/1ps
package game_pkg;

  typedef logic [7:0] bcd2_t;

  typedef enum logic [1:0] {
    EOG_IDLE,
    EOG_RUN,
    EOG_SCORE
  } eog_state_t;

  localparam int unsigned DEF_TICK_DIV       = 1_000_000;
  localparam int unsigned DEF_DURATION_TICKS = 100;
  localparam int unsigned DEF_BLINK_TICKS    = 10;

  localparam bcd2_t BCD2_ZERO = 8'h00;
  localparam bcd2_t BCD2_MAX  = 8'h99;

  // Two-digit BCD increment that holds at 99 instead of wrapping.
  function automatic bcd2_t bcd2_sat_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v != BCD2_MAX) begin
      if (v[3:0] == 4'd9) begin
        r = {v[7:4] + 4'd1, 4'd0};
      end else begin
        r = {v[7:4], v[3:0] + 4'd1};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_end_timer_scoreboard_bcd2.sv
// Saturating two-digit BCD score counter with synchronous clear (clear beats increment).
`timescale 1ns/1ps
module bcd2_sat_counter
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  inc,
  output bcd2_t value
);

  bcd2_t r_value;
  bcd2_t w_next;

  always_comb begin
    w_next = r_value;
    if (clr) begin
      w_next = BCD2_ZERO;
    end else if (inc) begin
      w_next = bcd2_sat_inc(r_value);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= BCD2_ZERO;
    end else begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/game_end_timer_scoreboard.sv
// End-of-game pause timer: returns running to the game FSM, drives the win/loss
// indicator and keeps saturating BCD win/loss scores.
`timescale 1ns/1ps
module game_end_timer_scoreboard
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned DURATION_TICKS = DEF_DURATION_TICKS,
  parameter int unsigned BLINK_TICKS    = DEF_BLINK_TICKS
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  game_won,
  input  logic  score_clear,
  output logic  running,
  output logic  result_led,
  output bcd2_t win_bcd,
  output bcd2_t loss_bcd
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned TW = $clog2(DURATION_TICKS + 1);
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(DURATION_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  eog_state_t    r_state;
  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_ticks;
  logic [BW-1:0] r_blink;
  logic          r_phase;

  logic w_tick;
  logic w_score;
  logic w_win_inc;
  logic w_loss_inc;

  assign w_tick = (r_state == EOG_RUN) && (r_pre == PRE_LAST);

  // A start pulse (re)arms the pause from any state; in SCORE the score is still
  // taken this cycle because the increment strobes below depend only on r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EOG_IDLE;
      r_pre   <= '0;
      r_ticks <= '0;
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (start) begin
      r_state <= EOG_RUN;
      r_pre   <= '0;
      r_ticks <= '0;
      r_blink <= '0;
      r_phase <= 1'b1;
    end else begin
      case (r_state)
        EOG_IDLE: begin
          r_state <= EOG_IDLE;
        end
        EOG_RUN: begin
          if (w_tick) begin
            r_pre   <= '0;
            r_ticks <= r_ticks + TW'(1);
            if (r_ticks == TICK_LAST) begin
              r_state <= EOG_SCORE;
            end
            if (r_blink == BLINK_LAST) begin
              r_blink <= '0;
              r_phase <= ~r_phase;
            end else begin
              r_blink <= r_blink + BW'(1);
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end
        EOG_SCORE: begin
          r_state <= EOG_IDLE;
        end
        default: begin
          r_state <= EOG_IDLE;
        end
      endcase
    end
  end

  // The FSM samples running in the same cycle it pulses start, hence the bypass term.
  assign running    = start | (r_state == EOG_RUN);
  assign result_led = (r_state == EOG_RUN) & (game_won | r_phase);

  assign w_score    = (r_state == EOG_SCORE);
  assign w_win_inc  = w_score & game_won;
  assign w_loss_inc = w_score & ~game_won;

  bcd2_sat_counter u_win_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clear),
    .inc   (w_win_inc),
    .value (win_bcd)
  );

  bcd2_sat_counter u_loss_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clear),
    .inc   (w_loss_inc),
    .value (loss_bcd)
  );

endmodule

// File: tb/tb_game_end_timer_scoreboard.sv
// Directed bench for game_end_timer_scoreboard with TICK_DIV=4, DURATION_TICKS=5, BLINK_TICKS=2.
`timescale 1ns/1ps
module tb_game_end_timer_scoreboard;

  logic       clk;
  logic       rst;
  logic       start;
  logic       game_won;
  logic       score_clear;
  logic       running;
  logic       result_led;
  logic [7:0] win_bcd;
  logic [7:0] loss_bcd;

  int n_checks;
  int n_pass;

  game_end_timer_scoreboard #(
    .TICK_DIV       (4),
    .DURATION_TICKS (5),
    .BLINK_TICKS    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .game_won    (game_won),
    .score_clear (score_clear),
    .running     (running),
    .result_led  (result_led),
    .win_bcd     (win_bcd),
    .loss_bcd    (loss_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       gw;
    int         raise_off;
    logic       clr;
    logic [7:0] exp_win;
    logic [7:0] exp_loss;
    string      name;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  // Pause of 20 RUN cycles (offsets 1..20); blink half-period is 8 cycles starting high.
  function automatic logic exp_led(input int o, input logic gw);
    if (o < 1 || o > 20) return 1'b0;
    if (gw) return 1'b1;
    return (((o - 1) / 8) % 2) == 0;
  endfunction

  // Offset 0 is the start cycle, 21 the SCORE cycle, 22 the first cycle with updated scores.
  task automatic run_pause(input logic gw, input int raise_off, input logic clr,
                           input logic [7:0] ew, input logic [7:0] el, input string tag);
    logic g;
    g = gw;
    for (int o = 0; o <= 22; o++) begin
      start = (o == 0);
      if (raise_off > 0 && o == raise_off) g = 1'b1;
      game_won    = g;
      score_clear = clr && (o == 21);
      #3;
      check({tag, " running"}, 8'(running), 8'(o <= 20));
      check({tag, " result_led"}, 8'(result_led), 8'(exp_led(o, g)));
      if (o == 22) begin
        check({tag, " win_bcd"}, win_bcd, ew);
        check({tag, " loss_bcd"}, loss_bcd, el);
      end
      next_cycle();
    end
    start       = 1'b0;
    game_won    = 1'b0;
    score_clear = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    game_won    = 1'b0;
    score_clear = 1'b0;

    vecs[0] = '{gw: 1'b1, raise_off: 0,  clr: 1'b0, exp_win: 8'h01, exp_loss: 8'h00, name: "win_pause"};
    vecs[1] = '{gw: 1'b0, raise_off: 10, clr: 1'b0, exp_win: 8'h02, exp_loss: 8'h00, name: "late_win"};
    vecs[2] = '{gw: 1'b0, raise_off: 0,  clr: 1'b0, exp_win: 8'h02, exp_loss: 8'h01, name: "loss_pause"};
    vecs[3] = '{gw: 1'b1, raise_off: 0,  clr: 1'b1, exp_win: 8'h00, exp_loss: 8'h00, name: "clear_in_score"};

    #2;
    check("reset running", 8'(running), 8'h00);
    check("reset result_led", 8'(result_led), 8'h00);
    check("reset win_bcd", win_bcd, 8'h00);
    check("reset loss_bcd", loss_bcd, 8'h00);
    next_cycle();
    rst = 1'b0;

    for (int c = 0; c < 9; c++) begin
      #3;
      check("idle running", 8'(running), 8'h00);
      next_cycle();
    end

    foreach (vecs[i]) begin
      run_pause(vecs[i].gw, vecs[i].raise_off, vecs[i].clr,
                vecs[i].exp_win, vecs[i].exp_loss, vecs[i].name);
      next_cycle();
    end

    // Retrigger at offset 10: one continuous high window to offset 30, one score.
    for (int o = 0; o <= 32; o++) begin
      start    = (o == 0 || o == 10);
      game_won = 1'b1;
      #3;
      check("retrig running", 8'(running), 8'(o <= 30));
      if (o == 31) check("retrig win before score", win_bcd, 8'h00);
      if (o == 32) begin
        check("retrig win after score", win_bcd, 8'h01);
        check("retrig loss", loss_bcd, 8'h00);
      end
      next_cycle();
    end
    start    = 1'b0;
    game_won = 1'b0;
    #3;
    check("retrig single score", win_bcd, 8'h01);
    next_cycle();

    // Clear while idle.
    score_clear = 1'b1;
    next_cycle();
    score_clear = 1'b0;
    #3;
    check("idle clear win", win_bcd, 8'h00);
    check("idle clear loss", loss_bcd, 8'h00);
    next_cycle();

    // Count up to saturation, passing the 09->10 carry on the way.
    for (int i = 1; i <= 100; i++) begin
      run_pause(1'b1, 0, 1'b0, to_bcd(i), 8'h00, $sformatf("sat%0d", i));
    end
    #3;
    check("saturated win", win_bcd, 8'h99);
    next_cycle();

    // Async reset mid-pause: running drops without a clock, scores cleared, nothing scored later.
    for (int o = 0; o < 5; o++) begin
      start = (o == 0);
      next_cycle();
    end
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst running", 8'(running), 8'h00);
    check("rst win", win_bcd, 8'h00);
    check("rst loss", loss_bcd, 8'h00);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      #3;
      check("post rst running", 8'(running), 8'h00);
      check("post rst led", 8'(result_led), 8'h00);
      next_cycle();
    end
    check("post rst win", win_bcd, 8'h00);
    check("post rst loss", loss_bcd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
